// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: stall bus
// width, per-stage stall bit positions and the mult/div sequencer states.
package pipe_ctrl_pkg;

    localparam int STALL_BUS_W = 6;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MD_START = 2'd1,
        ST_MD_WAIT  = 2'd2,
        ST_MD_DONE  = 2'd3
    } md_state_t;

endpackage

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller for the five-stage core. It merges the ID
// load-use stall, MEM exception flushes and the EX mult/div sequencing into
// one stall vector, and counts stalled cycles in a saturating counter.
//
// Mult/div handshake: md_start is a one-cycle pulse issued in MD_START.
// The unit answers with md_ready (pulse or level) no earlier than the cycle
// after md_start; md_ready is only sampled in MD_WAIT. md_cancel is a
// one-cycle pulse telling the unit to drop the operation in flight (after
// an exception or a timeout); the unit needs no acknowledgement.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W    = STALL_BUS_W,
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id,
    input  logic               md_req,
    input  logic               md_ready,
    input  logic               excp_req,
    input  logic [31:0]        excp_pc,
    input  logic               cnt_clr,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               md_start,
    output logic               md_cancel,
    output logic               md_timeout,
    output logic [CNT_W-1:0]   stall_cycles,
    output md_state_t          state_dbg
);

    localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    md_state_t         state;
    md_state_t         state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ex_stall;
    logic              timeout_hit;

    assign state_dbg = state;

    // Next-state logic of the mult/div sequencer; an exception always wins.
    always_comb begin
        state_nxt   = state;
        ex_stall    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                ex_stall = md_req;
                if (md_req) begin
                    state_nxt = ST_MD_START;
                end
            end
            ST_MD_START: begin
                ex_stall  = 1'b1;
                state_nxt = ST_MD_WAIT;
            end
            ST_MD_WAIT: begin
                ex_stall = 1'b1;
                if (md_ready) begin
                    state_nxt = ST_MD_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_MD_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (excp_req) begin
            state_nxt   = ST_IDLE;
            timeout_hit = 1'b0;
        end
    end

    // Stall vector, flush and redirect; forced quiet while reset is held.
    always_comb begin
        stall  = '0;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (rst) begin
            flush  = excp_req;
            new_pc = excp_req ? excp_pc : 32'h0;
            if (!excp_req && (ex_stall || stallreq_id)) begin
                stall[STALL_PC] = 1'b1;
                stall[STALL_IF] = 1'b1;
                stall[STALL_ID] = 1'b1;
                // EX holds only for mult/div; a load-use bubble goes into EX.
                stall[STALL_EX] = ex_stall;
                // MEM and WB keep draining so the bubble moves down the pipe.
                stall[STALL_MEM] = 1'b0;
                stall[STALL_WB]  = 1'b0;
            end
        end
    end

    // Sequencer state, wait counter and the registered handshake pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            md_start   <= 1'b0;
            md_cancel  <= 1'b0;
            md_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            md_start  <= (state_nxt == ST_MD_START);
            md_cancel <= (excp_req && ((state == ST_MD_START) || (state == ST_MD_WAIT)))
                         || timeout_hit;
            if (timeout_hit) begin
                md_timeout <= 1'b1;
            end
            if (state == ST_MD_START) begin
                wait_cnt <= '0;
            end else if (state == ST_MD_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    // Saturating stalled-cycle counter; clear beats increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
        end else if (stall[STALL_PC] && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked every
// cycle against a cycle-age model of the mult/div sequencing.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int CNT_W = 8;
    localparam int TMO   = 64;
    localparam int W     = 52;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        md_req = 1'b0;
    logic        md_ready = 1'b0;
    logic        excp_req = 1'b0;
    logic [31:0] excp_pc = 32'h0;
    logic        cnt_clr = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        md_start;
    logic        md_cancel;
    logic        md_timeout;
    logic [CNT_W-1:0] stall_cycles;
    md_state_t   state_dbg;

    always #5 clk = ~clk;

    pipe_ctrl #(.STALL_W(6), .MD_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .md_req(md_req),
        .md_ready(md_ready), .excp_req(excp_req), .excp_pc(excp_pc),
        .cnt_clr(cnt_clr), .stall(stall), .flush(flush), .new_pc(new_pc),
        .md_start(md_start), .md_cancel(md_cancel), .md_timeout(md_timeout),
        .stall_cycles(stall_cycles), .state_dbg(state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_age: -1 when no mult/div is in flight, 1 in the start cycle, and
    // 2 + k on the k-th wait cycle after the start pulse.
    int m_age;
    bit m_done;
    bit m_cancel;
    bit m_timeout;
    int m_cnt;

    task automatic model_reset();
        m_age = -1; m_done = 0; m_cancel = 0; m_timeout = 0; m_cnt = 0;
    endtask

    function automatic logic [W-1:0] model_exp();
        logic [5:0]  s;
        logic        ex;
        logic        fl;
        logic [31:0] pc;
        logic [1:0]  st;
        s = 6'b0; fl = 1'b0; pc = 32'h0;
        if (rst) begin
            ex = (m_age < 0 && !m_done && md_req) || (m_age >= 1);
            if (excp_req)         s = 6'b000000;
            else if (ex)          s = 6'b001111;
            else if (stallreq_id) s = 6'b000111;
            fl = excp_req;
            pc = excp_req ? excp_pc : 32'h0;
        end
        if (m_done)          st = ST_MD_DONE;
        else if (m_age == 1) st = ST_MD_START;
        else if (m_age >= 2) st = ST_MD_WAIT;
        else                 st = ST_IDLE;
        return {s, fl, pc, (m_age == 1), m_cancel, m_timeout, CNT_W'(m_cnt), st};
    endfunction

    task automatic model_step();
        logic [W-1:0] v;
        v = model_exp();
        if (cnt_clr) m_cnt = 0;
        else if (v[46] && m_cnt < CMAX) m_cnt++;
        m_cancel = 0;
        if (excp_req) begin
            m_cancel = (m_age >= 1);
            m_age = -1; m_done = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_age < 0) begin
            if (md_req) m_age = 1;
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (md_ready) begin
            m_done = 1; m_age = -1;
        end else if (m_age - 2 == TMO - 1) begin
            m_age = -1; m_cancel = 1; m_timeout = 1;
        end else begin
            m_age++;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];

    initial forever begin
        @(negedge clk);
        exp_q.push_back(model_exp());
    end

    initial forever begin
        logic [W-1:0] e;
        @(negedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_queue_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk("stall",        stall,        e[51:46]);
            chk("flush",        flush,        e[45]);
            chk("new_pc",       new_pc,       e[44:13]);
            chk("md_start",     md_start,     e[12]);
            chk("md_cancel",    md_cancel,    e[11]);
            chk("md_timeout",   md_timeout,   e[10]);
            chk("stall_cycles", stall_cycles, e[9:2]);
            chk("state",        state_dbg,    e[1:0]);
        end
    end

    // Directed-scenario monitors.
    int n_ex_stall = 0;
    int n_start = 0;
    always @(negedge clk) begin
        if (stall === 6'b001111) n_ex_stall <= n_ex_stall + 1;
        if (md_start === 1'b1)   n_start    <= n_start + 1;
    end

    // ---------------- driver tasks ----------------
    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_id = 0; md_req = 0; md_ready = 0; excp_req = 0; excp_pc = 0; cnt_clr = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int got;
        // Reset state
        cycle(3);
        chk("rst_stall", stall, 0);
        chk("rst_cnt", stall_cycles, 0);
        chk("rst_state", state_dbg, ST_IDLE);
        rst = 1;
        cycle(1);

        // Load-use stall for two cycles
        stallreq_id = 1;
        #1 chk("id_stall", stall, 6'b000111);
        cycle(2);
        stallreq_id = 0;
        chk("id_cnt", stall_cycles, 2);
        cycle(2);

        // Mult/div with md_ready 5 cycles after md_start
        n_ex_stall = 0; n_start = 0;
        md_req = 1;
        cycle(1);
        cycle(5);
        md_ready = 1;
        cycle(1);
        md_ready = 0; md_req = 0;
        #1 chk("md_done_state", state_dbg, ST_MD_DONE);
        chk("md_done_stall", stall, 0);
        cycle(2);
        chk("md_ex_cycles", n_ex_stall, 7);
        chk("md_start_cycles", n_start, 1);

        // Exception during MD_WAIT
        md_req = 1;
        cycle(3);
        excp_req = 1; excp_pc = 32'hBFC00380;
        #1 chk("excp_flush", flush, 1);
        chk("excp_pc", new_pc, 32'hBFC00380);
        chk("excp_stall", stall, 0);
        cycle(1);
        excp_req = 0; md_req = 0;
        #1 chk("excp_cancel", md_cancel, 1);
        chk("excp_state", state_dbg, ST_IDLE);
        cycle(2);

        // Exception and md_ready together: MD_DONE skipped
        md_req = 1;
        cycle(6);
        excp_req = 1; md_ready = 1; excp_pc = 32'h8000_0180;
        cycle(1);
        excp_req = 0; md_ready = 0; md_req = 0;
        #1 chk("race_cancel", md_cancel, 1);
        chk("race_state", state_dbg, ST_IDLE);
        cycle(2);

        // Timeout with no md_ready
        md_req = 1;
        got = 0;
        for (int i = 1; i <= 200; i++) begin
            cycle(1);
            if (md_cancel === 1'b1) begin
                got = i;
                break;
            end
        end
        chk("tmo_latency", got, 66);
        chk("tmo_flag", md_timeout, 1);
        chk("tmo_state", state_dbg, ST_IDLE);
        cycle(1);
        chk("tmo_restart_state", state_dbg, ST_MD_START);
        chk("tmo_restart_start", md_start, 1);
        chk("tmo_sticky", md_timeout, 1);
        md_req = 0; excp_req = 1;
        cycle(1);
        excp_req = 0;
        cycle(2);

        // Reset mid MD_WAIT
        md_req = 1;
        cycle(4);
        rst = 0;
        #1 chk("arst_stall", stall, 0);
        chk("arst_start", md_start, 0);
        chk("arst_cancel", md_cancel, 0);
        chk("arst_timeout", md_timeout, 0);
        chk("arst_cnt", stall_cycles, 0);
        chk("arst_state", state_dbg, ST_IDLE);
        cycle(2);
        md_req = 0; rst = 1;
        cycle(1);
        chk("arst_rel_state", state_dbg, ST_IDLE);

        // Counter saturation and clear
        stallreq_id = 1;
        cycle(300);
        chk("sat_cnt", stall_cycles, CMAX);
        cnt_clr = 1;
        cycle(1);
        cnt_clr = 0; stallreq_id = 0;
        chk("clr_cnt", stall_cycles, 0);
        cycle(1);
        chk("clr_hold", stall_cycles, 0);

        // Random traffic: frequent md_ready, then rare md_ready for timeouts
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 2500; i++) begin
                stallreq_id = ($urandom_range(0, 3) == 0);
                md_req      = ($urandom_range(0, 2) != 0);
                md_ready    = (ph == 0) ? ($urandom_range(0, 7) == 0)
                                        : ($urandom_range(0, 120) == 0);
                excp_req    = ($urandom_range(0, 59) == 0);
                excp_pc     = $urandom;
                cnt_clr     = ($urandom_range(0, 199) == 0);
                cycle(1);
            end
        end
        idle_inputs();
        cycle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
